// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer.
//   NCH  : number of mux channels
//   SELW : width of the channel select
//   CNTW : width of the dwell counter (settle time 0..15)
package mux_scan_ctrl_pkg;

    localparam int unsigned NCH  = 16;
    localparam int unsigned SELW = 4;
    localparam int unsigned CNTW = 4;

    // REPORT is not a state: it happens on the last capture edge of DWELL.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_e;

endpackage

// File: rtl/mux_scan_next.sv
// Combinational channel search for the scan sequencer.
//   mask  in  NCH   channel enables
//   cur   in  SELW  current channel
//   first in  1     1 = return the lowest enabled channel, ignoring cur
//   nxt   out SELW  next enabled channel above cur (0 when none)
//   last  out 1     no enabled channel remains above cur
module mux_scan_next
    import mux_scan_ctrl_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] cur,
    input  logic            first,
    output logic [SELW-1:0] nxt,
    output logic            last
);

    // Scan from the top down so the lowest qualifying index is written last.
    always_comb begin
        nxt  = '0;
        last = 1'b1;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (mask[i-1] && (first || (SELW'(i-1) > cur))) begin
                nxt  = SELW'(i-1);
                last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer driving the select of a 16:1 mux and sampling its output.
//   clk, resetn   clock, asynchronous active-low reset
//   start         begin a sweep (IDLE only); latches mask and cont
//   abort         synchronous stop, wins over everything but reset
//   cont          1 = continuous sweeps, 0 = single sweep
//   mask          channel enables
//   f             mux output
//   t             mux select
//   sample        last completed sweep word
//   valid         one-cycle pulse when sample updates
//   changed       with valid: new sample differs from the previous one
//   busy          sweep in progress
//   done          one-cycle pulse at end of single sweep, abort, or empty start
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            abort,
    input  logic            cont,
    input  logic [NCH-1:0]  mask,
    input  logic            f,
    output logic [SELW-1:0] t,
    output logic [NCH-1:0]  sample,
    output logic            valid,
    output logic            changed,
    output logic            busy,
    output logic            done
);

    localparam logic [CNTW-1:0] SETTLE = CNTW'(SETTLE_CYCLES);

    state_e          state_q, state_d;
    logic [SELW-1:0] t_q, t_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic            cont_q, cont_d;
    logic [NCH-1:0]  shadow_q, shadow_d;
    logic [NCH-1:0]  sample_q, sample_d;
    logic            valid_q, valid_d;
    logic            changed_q, changed_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NCH-1:0]  first_mask;
    logic [SELW-1:0] first_ch;
    logic            first_none;
    logic [SELW-1:0] next_ch;
    logic            next_last;
    logic [NCH-1:0]  cap_word;

    // In IDLE the live mask is searched since it is only latched on this edge.
    assign first_mask = (state_q == ST_IDLE) ? mask : mask_q;

    mux_scan_next u_first (
        .mask  (first_mask),
        .cur   ('0),
        .first (1'b1),
        .nxt   (first_ch),
        .last  (first_none)
    );

    mux_scan_next u_next (
        .mask  (mask_q),
        .cur   (t_q),
        .first (1'b0),
        .nxt   (next_ch),
        .last  (next_last)
    );

    // Shadow with the current channel's bit replaced by f.
    always_comb begin
        cap_word      = shadow_q;
        cap_word[t_q] = f;
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        cont_d    = cont_q;
        shadow_d  = shadow_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        changed_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (abort) begin
            state_d  = ST_IDLE;
            t_d      = '0;
            cnt_d    = '0;
            shadow_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mask_d = mask;
                        cont_d = cont;
                        if (first_none) begin
                            done_d = 1'b1;
                        end else begin
                            state_d  = ST_DWELL;
                            t_d      = first_ch;
                            cnt_d    = '0;
                            shadow_d = '0;
                            busy_d   = 1'b1;
                        end
                    end
                end
                ST_DWELL: begin
                    if (cnt_q == SETTLE) begin
                        cnt_d = '0;
                        if (!next_last) begin
                            t_d      = next_ch;
                            shadow_d = cap_word;
                        end else begin
                            // Last capture edge doubles as the report edge.
                            sample_d  = cap_word;
                            valid_d   = 1'b1;
                            changed_d = (cap_word != sample_q);
                            shadow_d  = '0;
                            if (cont_q) begin
                                t_d = first_ch;
                            end else begin
                                state_d = ST_IDLE;
                                t_d     = '0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            t_q       <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            cont_q    <= 1'b0;
            shadow_q  <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            cont_q    <= cont_d;
            shadow_q  <= shadow_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign t       = t_q;
    assign sample  = sample_q;
    assign valid   = valid_q;
    assign changed = changed_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
